// File: rtl/neuron_pkg.sv
// Shared types and helpers for the sequential neuron: sign-magnitude Q4.11 data, FSM states.
// No clocked logic; functions are combinational.
package neuron_pkg;

  localparam int SM_W = 16;
  localparam int FRAC_BITS = 11;
  localparam logic [SM_W-1:0] SM_ZERO = 16'h0000;

  typedef enum logic [1:0] {IDLE, ACCUM, ACT, OUT} state_t;

  // 0x8000 (negative zero) maps to 0.
  function automatic logic signed [SM_W:0] sm_to_tc(input logic [SM_W-1:0] v);
    logic signed [SM_W:0] m;
    m = {2'b00, v[SM_W-2:0]};
    return v[SM_W-1] ? -m : m;
  endfunction

  function automatic logic [31:0] tc_abs_sat(input logic signed [31:0] v, input int w);
    logic [31:0] mag;
    logic [31:0] lim;
    mag = (v < 0) ? -v : v;
    lim = (32'd1 << w) - 32'd1;
    return (mag > lim) ? lim : mag;
  endfunction

endpackage

// File: rtl/Sigmoid_LUT.sv
// Piecewise-linear sigmoid of a sign-magnitude Q.11 sum; output is a Q4.11 probability in [0,1].
// Purely combinational, no flow control.
module Sigmoid_LUT #(
  parameter int SUM_W = 22
) (
  input  logic [SUM_W-1:0] suma,
  input  logic             predznak,
  output logic [15:0]      vjerojatnost
);

  logic [14:0] y;

  // Segments break at |x| = 1.0, 2.375 and 5.0; negative side uses 1 - f(|x|).
  always_comb begin
    if (suma >= SUM_W'(10240)) begin
      y = 15'd2048;
    end else if (suma >= SUM_W'(4864)) begin
      y = 15'(suma >> 5) + 15'd1728;
    end else if (suma >= SUM_W'(2048)) begin
      y = 15'(suma >> 3) + 15'd1280;
    end else begin
      y = 15'(suma >> 2) + 15'd1024;
    end
    vjerojatnost = {1'b0, predznak ? (15'd2048 - y) : y};
  end

endmodule

// File: rtl/mnozenje.sv
// Sign-magnitude Q4.11 multiplier; magnitude saturates to 0x7FFF and zero is always +0.
// Purely combinational, no flow control.
module mnozenje
  import neuron_pkg::*;
(
  input  logic [15:0] weight,
  input  logic [15:0] sample,
  output logic [15:0] product
);

  logic [18:0] mag;

  always_comb begin
    mag = 19'((30'(weight[14:0]) * 30'(sample[14:0])) >> FRAC_BITS);
    if (mag == 19'd0) begin
      product = SM_ZERO;
    end else begin
      product = {weight[15] ^ sample[15], (mag > 19'd32767) ? 15'h7FFF : mag[14:0]};
    end
  end

endmodule

// File: rtl/neuron_weight_mem.sv
// Weight store: one write port, LANES combinational read ports at beat*LANES+k.
// Write takes effect at the clock edge; reads see the old value in the same cycle.
module neuron_weight_mem
  import neuron_pkg::*;
#(
  parameter int N_INPUTS = 60,
  parameter int LANES    = 4,
  parameter int BW       = 4
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [$clog2(N_INPUTS)-1:0] w_addr,
  input  logic [SM_W-1:0]             w_data,
  input  logic [BW-1:0]               beat,
  output logic [LANES*SM_W-1:0]       rdata
);

  localparam int AW = $clog2(N_INPUTS);

  logic [SM_W-1:0] mem [N_INPUTS];

  always_ff @(posedge clk) begin
    if (we) mem[w_addr] <= w_data;
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < LANES; k++) begin
      rdata[k*SM_W +: SM_W] = mem[AW'(int'(beat) * LANES + k)];
    end
  end

endmodule

// File: rtl/neuron_seq_mac.sv
// Sequential MAC neuron: LANES samples/beat, bias + weighted sum, sigmoid or linear output.
// Result valid 2 cycles after the final beat; no new frame accepted until the result is taken.
module neuron_seq_mac
  import neuron_pkg::*;
#(
  parameter int N_INPUTS = 60,
  parameter int LANES    = 4,
  parameter int SUM_W    = 22,
  parameter int ACC_W    = 24
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        act_bypass,
  input  logic [15:0]                 bias,
  input  logic                        w_we,
  input  logic [$clog2(N_INPUTS)-1:0] w_addr,
  input  logic [15:0]                 w_data,
  output logic                        w_err,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [16*LANES-1:0]         s_data,
  input  logic                        s_last,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [15:0]                 m_data,
  output logic                        frame_err
);

  localparam int N_BEATS = N_INPUTS / LANES;
  localparam int BW = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

  state_t                   state;
  logic signed [ACC_W-1:0]  acc;
  logic [BW-1:0]            beat_cnt;
  logic                     err_acc;
  logic                     byp_q;

  logic [LANES*SM_W-1:0]    w_rd;
  logic [LANES*SM_W-1:0]    prod;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W-1:0]  lane_sum;
  logic                     final_beat;
  logic                     predznak;
  logic [SUM_W-1:0]         generalna_suma;
  logic [14:0]              lin_mag;
  logic [15:0]              sig_out;

  neuron_weight_mem #(
    .N_INPUTS (N_INPUTS),
    .LANES    (LANES),
    .BW       (BW)
  ) u_wmem (
    .clk    (clk),
    .we     (w_we && (state == IDLE)),
    .w_addr (w_addr),
    .w_data (w_data),
    .beat   (beat_cnt),
    .rdata  (w_rd)
  );

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    mnozenje u_mul (
      .weight  (w_rd[k*SM_W +: SM_W]),
      .sample  (s_data[k*SM_W +: SM_W]),
      .product (prod[k*SM_W +: SM_W])
    );
  end

  Sigmoid_LUT #(.SUM_W(SUM_W)) u_sig (
    .suma         (generalna_suma),
    .predznak     (predznak),
    .vjerojatnost (sig_out)
  );

  always_comb begin
    acc_base = (state == IDLE) ? ACC_W'(sm_to_tc(bias)) : acc;
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_sum = lane_sum + ACC_W'(sm_to_tc(prod[k*SM_W +: SM_W]));
    end
    final_beat     = (beat_cnt == BW'(N_BEATS - 1));
    predznak       = (acc < 0);
    generalna_suma = SUM_W'(tc_abs_sat(32'(acc), SUM_W));
    lin_mag        = 15'(tc_abs_sat(32'(acc), 15));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      beat_cnt  <= '0;
      err_acc   <= 1'b0;
      byp_q     <= 1'b0;
      s_ready   <= 1'b1;
      m_valid   <= 1'b0;
      m_data    <= SM_ZERO;
      frame_err <= 1'b0;
      w_err     <= 1'b0;
    end else begin
      w_err <= w_we && (state != IDLE);
      case (state)
        IDLE, ACCUM: begin
          if (s_valid) begin
            acc     <= acc_base + lane_sum;
            // s_last only flags a mismatch; frame length is fixed by the beat count.
            err_acc <= ((state == ACCUM) && err_acc) || (s_last != final_beat);
            if (state == IDLE) byp_q <= act_bypass;
            if (final_beat) begin
              state    <= ACT;
              s_ready  <= 1'b0;
              beat_cnt <= '0;
            end else begin
              state    <= ACCUM;
              beat_cnt <= beat_cnt + BW'(1);
            end
          end
        end
        ACT: begin
          m_data    <= byp_q ? {predznak, lin_mag} : sig_out;
          frame_err <= err_acc;
          m_valid   <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_seq_mac.sv
// Directed bench: small 4x1 neuron for arithmetic/flow corners, 60x4 neuron for lane mapping and s_last.
module tb_neuron_seq_mac;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_byp, a_w_we, a_w_err, a_s_valid, a_s_ready, a_s_last;
  logic        a_m_valid, a_m_ready, a_ferr;
  logic [15:0] a_bias, a_w_data, a_s_data, a_m_data;
  logic [1:0]  a_w_addr;

  logic        b_byp, b_w_we, b_w_err, b_s_valid, b_s_ready, b_s_last;
  logic        b_m_valid, b_m_ready, b_ferr;
  logic [15:0] b_bias, b_w_data, b_m_data;
  logic [63:0] b_s_data;
  logic [5:0]  b_w_addr;

  int errors = 0;
  int checks = 0;

  neuron_seq_mac #(.N_INPUTS(4), .LANES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .act_bypass(a_byp), .bias(a_bias),
    .w_we(a_w_we), .w_addr(a_w_addr), .w_data(a_w_data), .w_err(a_w_err),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data), .s_last(a_s_last),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data), .frame_err(a_ferr)
  );

  neuron_seq_mac #(.N_INPUTS(60), .LANES(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .act_bypass(b_byp), .bias(b_bias),
    .w_we(b_w_we), .w_addr(b_w_addr), .w_data(b_w_data), .w_err(b_w_err),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_last(b_s_last),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .frame_err(b_ferr)
  );

  typedef struct {
    logic [15:0] w;
    logic [15:0] x;
    logic [15:0] bias;
    logic        byp;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic a_load(input logic [15:0] w);
    for (int i = 0; i < 4; i++) begin
      a_w_we = 1'b1; a_w_addr = 2'(i); a_w_data = w;
      tick;
    end
    a_w_we = 1'b0;
  endtask

  task automatic a_send(input logic [15:0] x, input logic [15:0] bias, input logic byp,
                        input int last_pos, input int first, input int nbeats);
    for (int b = first; b < nbeats; b++) begin
      a_s_valid = 1'b1; a_s_data = x; a_s_last = (b == last_pos);
      a_bias = bias; a_byp = byp;
      chk($sformatf("a_s_ready_beat%0d", b), a_s_ready, 1);
      tick;
    end
    a_s_valid = 1'b0; a_s_last = 1'b0;
  endtask

  // Called right after the final beat's edge: ACT cycle, then OUT.
  task automatic a_result(input string name, input logic [15:0] exp_data, input logic exp_ferr);
    int n;
    chk({name, "_act_mvalid"}, a_m_valid, 0);
    chk({name, "_act_sready"}, a_s_ready, 0);
    tick;
    chk({name, "_lat_mvalid"}, a_m_valid, 1);
    n = 0;
    while (!a_m_valid && n < 8) begin tick; n++; end
    chk({name, "_data"}, a_m_data, exp_data);
    chk({name, "_ferr"}, a_ferr, exp_ferr);
    a_m_ready = 1'b1;
    tick;
    a_m_ready = 1'b0;
    chk({name, "_done_mvalid"}, a_m_valid, 0);
    chk({name, "_done_sready"}, a_s_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h0800, 16'h0800, 16'h0000, 1'b1, 16'h2000};
    vecs[1] = '{16'h8800, 16'h0800, 16'h0400, 1'b1, 16'h9C00};
    vecs[2] = '{16'h7FFF, 16'h7FFF, 16'h0000, 1'b1, 16'h7FFF};
    vecs[3] = '{16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 16'h0800};
    vecs[4] = '{16'h0000, 16'h1234, 16'h0000, 1'b0, 16'h0400};
    vecs[5] = '{16'h8800, 16'h0800, 16'h0400, 1'b0, 16'h0060};
    vecs[6] = '{16'h8000, 16'h0800, 16'h8000, 1'b1, 16'h0000};
    vecs[7] = '{16'h8800, 16'h8800, 16'h8400, 1'b1, 16'h1C00};
    vecs[8] = '{16'h7FFF, 16'hFFFF, 16'h0000, 1'b1, 16'hFFFF};

    rst_n = 1'b0;
    a_byp = 1'b1; a_bias = '0; a_w_we = 1'b0; a_w_addr = '0; a_w_data = '0;
    a_s_valid = 1'b0; a_s_data = '0; a_s_last = 1'b0; a_m_ready = 1'b0;
    b_byp = 1'b1; b_bias = '0; b_w_we = 1'b0; b_w_addr = '0; b_w_data = '0;
    b_s_valid = 1'b0; b_s_data = '0; b_s_last = 1'b0; b_m_ready = 1'b0;
    repeat (3) tick;
    chk("rst_m_valid", a_m_valid, 0);
    chk("rst_m_data", a_m_data, 0);
    chk("rst_frame_err", a_ferr, 0);
    chk("rst_w_err", a_w_err, 0);
    rst_n = 1'b1;
    tick;
    chk("rst_s_ready", a_s_ready, 1);

    for (int v = 0; v < 9; v++) begin
      a_load(vecs[v].w);
      a_send(vecs[v].x, vecs[v].bias, vecs[v].byp, 3, 0, 4);
      a_result($sformatf("vec%0d", v), vecs[v].exp_data, 1'b0);
    end

    // s_last early, then never: frame still 4 beats, only frame_err changes.
    a_load(16'h0800);
    a_send(16'h0800, 16'h0000, 1'b1, 1, 0, 4);
    a_result("last_early", 16'h2000, 1'b1);
    a_send(16'h0800, 16'h0000, 1'b1, 9, 0, 4);
    a_result("last_missing", 16'h2000, 1'b1);
    a_send(16'h0800, 16'h0000, 1'b1, 3, 0, 4);
    a_result("last_ok", 16'h2000, 1'b0);

    // Hold result under backpressure; a write during OUT is dropped.
    a_send(16'h0800, 16'h0000, 1'b1, 3, 0, 4);
    tick;
    a_w_we = 1'b1; a_w_addr = 2'd0; a_w_data = 16'h7FFF;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("hold%0d_m_valid", c), a_m_valid, 1);
      chk($sformatf("hold%0d_m_data", c), a_m_data, 16'h2000);
      chk($sformatf("hold%0d_s_ready", c), a_s_ready, 0);
      tick;
      if (c == 0) begin
        a_w_we = 1'b0;
        chk("w_err_pulse", a_w_err, 1);
      end else begin
        chk($sformatf("w_err_low%0d", c), a_w_err, 0);
      end
    end
    a_m_ready = 1'b1;
    tick;
    a_m_ready = 1'b0;
    a_send(16'h0800, 16'h0000, 1'b1, 3, 0, 4);
    a_result("weight_kept", 16'h2000, 1'b0);

    // Write in IDLE alongside the first beat: beat uses the old weight.
    a_w_we = 1'b1; a_w_addr = 2'd0; a_w_data = 16'h1000;
    a_s_valid = 1'b1; a_s_data = 16'h0800; a_s_last = 1'b0; a_bias = '0; a_byp = 1'b1;
    tick;
    a_w_we = 1'b0;
    chk("simul_w_err", a_w_err, 0);
    a_send(16'h0800, 16'h0000, 1'b1, 3, 1, 4);
    a_result("simul_old_weight", 16'h2000, 1'b0);
    a_send(16'h0800, 16'h0000, 1'b1, 3, 0, 4);
    a_result("simul_new_weight", 16'h2800, 1'b0);

    // Reset mid-frame discards the partial sum.
    a_load(16'h0800);
    a_send(16'h0800, 16'h0000, 1'b1, 3, 0, 2);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("midrst_m_valid", a_m_valid, 0);
    chk("midrst_s_ready", a_s_ready, 1);
    chk("midrst_m_data", a_m_data, 0);
    tick;
    a_send(16'h0800, 16'h0000, 1'b1, 3, 0, 4);
    a_result("post_rst", 16'h2000, 1'b0);

    // Wide neuron: w[1]=2.0 else 1.0, sample i = raw i -> sum 1771.
    for (int i = 0; i < 60; i++) begin
      b_w_we = 1'b1; b_w_addr = 6'(i); b_w_data = (i == 1) ? 16'h1000 : 16'h0800;
      tick;
    end
    b_w_we = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < 15; b++) begin
        b_s_valid = 1'b1;
        b_s_last = (f == 0) ? (b == 13) : (b == 14);
        b_bias = (f == 0) ? 16'h0000 : 16'h8800;
        b_byp = 1'b1;
        for (int k = 0; k < 4; k++) b_s_data[k*16 +: 16] = 16'(b * 4 + k);
        if (b == 14) chk($sformatf("b%0d_beat15_s_ready", f), b_s_ready, 1);
        tick;
      end
      b_s_valid = 1'b0; b_s_last = 1'b0;
      chk($sformatf("b%0d_act_mvalid", f), b_m_valid, 0);
      tick;
      chk($sformatf("b%0d_lat_mvalid", f), b_m_valid, 1);
      chk($sformatf("b%0d_data", f), b_m_data, (f == 0) ? 16'h06EB : 16'h8115);
      chk($sformatf("b%0d_ferr", f), b_ferr, (f == 0) ? 1 : 0);
      b_m_ready = 1'b1;
      tick;
      b_m_ready = 1'b0;
      chk($sformatf("b%0d_done_sready", f), b_s_ready, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
